// File: rtl/seq_divider_param_pkg.sv
// Shared RV32M types plus the divider state encoding and step limit.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_funct3_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int unsigned DIV_MAX_STEPS = 4;

endpackage

// File: rtl/seq_divider_param_div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // rem < dvsr holds on entry, so the difference sign bit is a valid compare
  assign w_sh   = {i_rem, i_quo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, i_dvsr};
  assign w_ge   = ~w_diff[WIDTH];
  assign o_rem  = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
  assign o_quo  = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_divider_param.sv
// Multi-cycle RV32M divider: restoring iterations, STEPS_PER_CYCLE per clock,
// with single-cycle results for divide-by-zero and signed overflow.
module seq_divider_param
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  m_funct3_t        funct3,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned ITERS = WIDTH / STEPS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(ITERS) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state;
  div_state_t       w_state_nx;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_signed;
  logic             w_div0;
  logic             w_ovf;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic [WIDTH-1:0] w_rem_ch [STEPS_PER_CYCLE+1];
  logic [WIDTH-1:0] w_quo_ch [STEPS_PER_CYCLE+1];

  assign w_signed  = (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign w_dvd_mag = (w_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_mag = (w_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign w_div0    = (divisor == '0);
  assign w_ovf     = w_signed && (dividend == MIN_VAL) && (divisor == '1);
  assign w_accept  = in_valid && r_in_ready && !flush;
  assign w_last    = (r_state == DIV_CALC) && (r_cnt == CNT_W'(ITERS - 1));

  assign w_rem_ch[0] = r_rem;
  assign w_quo_ch[0] = r_quo;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem  (w_rem_ch[g]),
      .i_quo  (w_quo_ch[g]),
      .i_dvsr (r_dvsr),
      .o_rem  (w_rem_ch[g+1]),
      .o_quo  (w_quo_ch[g+1])
    );
  end

  // Sign fix-up applied on the final iteration edge
  assign w_q_fin = r_neg_q ? -w_quo_ch[STEPS_PER_CYCLE] : w_quo_ch[STEPS_PER_CYCLE];
  assign w_r_fin = r_neg_r ? -w_rem_ch[STEPS_PER_CYCLE] : w_rem_ch[STEPS_PER_CYCLE];

  always_comb begin
    w_state_nx = r_state;
    if (flush) begin
      w_state_nx = DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: if (in_valid) w_state_nx = (w_div0 || w_ovf) ? DIV_DONE : DIV_CALC;
        DIV_CALC: if (w_last) w_state_nx = DIV_DONE;
        DIV_DONE: if (out_ready) w_state_nx = DIV_IDLE;
        default:  w_state_nx = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= DIV_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= (w_state_nx == DIV_IDLE);
      r_out_valid <= (w_state_nx == DIV_DONE);
      if (w_accept) begin
        r_rem   <= '0;
        r_quo   <= w_dvd_mag;
        r_dvsr  <= w_dvs_mag;
        r_cnt   <= '0;
        r_neg_q <= w_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_neg_r <= w_signed && dividend[WIDTH-1];
        if (w_div0) begin
          r_quotient  <= '1;
          r_remainder <= dividend;
        end else if (w_ovf) begin
          r_quotient  <= MIN_VAL;
          r_remainder <= '0;
        end
      end else if (r_state == DIV_CALC && !flush) begin
        r_rem <= w_rem_ch[STEPS_PER_CYCLE];
        r_quo <= w_quo_ch[STEPS_PER_CYCLE];
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_quotient  <= w_q_fin;
          r_remainder <= w_r_fin;
        end
      end
      // Result registers read as zero outside DONE
      if (w_state_nx != DIV_DONE) begin
        r_quotient  <= '0;
        r_remainder <= '0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_seq_divider_param.sv
// Randomized bench for seq_divider_param (STEPS 1 and 4) against an arithmetic model.
module tb_seq_divider_param;
  import rv32i_types::*;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv1, iv4, flush, out_ready;
  m_funct3_t    funct3;
  logic [W-1:0] dividend, divisor;
  logic         ir1, ov1, ir4, ov4;
  logic [W-1:0] q1, r1, q4, r4;
  logic         sel;
  logic         m_ir, m_ov;
  logic [W-1:0] m_q, m_r;
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  seq_divider_param #(.WIDTH(W), .STEPS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .funct3(funct3),
    .dividend(dividend), .divisor(divisor), .flush(flush), .out_valid(ov1),
    .out_ready(out_ready), .quotient(q1), .remainder(r1)
  );

  seq_divider_param #(.WIDTH(W), .STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .funct3(funct3),
    .dividend(dividend), .divisor(divisor), .flush(flush), .out_valid(ov4),
    .out_ready(out_ready), .quotient(q4), .remainder(r4)
  );

  assign m_ir = sel ? ir4 : ir1;
  assign m_ov = sel ? ov4 : ov1;
  assign m_q  = sel ? q4  : q1;
  assign m_r  = sel ? r4  : r1;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // RISC-V M semantics straight from the ISA rules
  function automatic void ref_model(input m_funct3_t f3, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input int steps, output logic [W-1:0] q, output logic [W-1:0] r,
                                    output int lat);
    logic signed [W-1:0] sa, sb;
    logic is_s;
    is_s = (f3 == F3_DIV) || (f3 == F3_REM);
    sa = a;
    sb = b;
    lat = int'(W) / steps + 1;
    if (b == 0) begin
      q = '1; r = a; lat = 1;
    end else if (is_s && a == MINV && b == '1) begin
      q = MINV; r = '0; lat = 1;
    end else if (is_s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  task automatic run(input logic s, input m_funct3_t f3, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int hold);
    logic [W-1:0] eq, er;
    int elat, lat;
    ref_model(f3, a, b, s ? 4 : 1, eq, er, elat);
    sel = s; funct3 = f3; dividend = a; divisor = b;
    if (s) iv4 = 1'b1; else iv1 = 1'b1;
    #0;
    chk("in_ready_before", W'(m_ir), W'(1));
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0;
    funct3 = m_funct3_t'($urandom_range(7)); dividend = $urandom; divisor = $urandom;
    lat = 1;
    while (!m_ov && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", W'(lat), W'(elat));
    chk("quotient", m_q, eq);
    chk("remainder", m_r, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_quotient", m_q, eq);
      chk("hold_remainder", m_r, er);
      chk("hold_in_ready", W'(m_ir), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after", W'(m_ov), W'(0));
    chk("in_ready_after", W'(m_ir), W'(1));
    chk("quotient_idle", m_q, W'(0));
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int n_ov;
    n_ov = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ov1) n_ov++;
    end
    chk(tag, W'(n_ov), W'(0));
  endtask

  initial begin
    m_funct3_t ops [4] = '{F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    logic [W-1:0] a, b;
    logic s;
    rst = 1'b1; iv1 = 1'b0; iv4 = 1'b0; flush = 1'b0; out_ready = 1'b0; sel = 1'b0;
    funct3 = F3_DIV; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(ov1), W'(0));
    chk("rst_quotient", q1, W'(0));
    chk("rst_remainder", r4, W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed cases from the ISA corner rules
    run(1'b0, F3_DIV,  32'hFFFF_FFF9, 32'h2, 5);
    run(1'b1, F3_DIVU, 32'hFFFF_FFFF, 32'h10, 0);
    run(1'b0, F3_REM,  32'h1234, 32'h0, 0);
    run(1'b0, F3_DIV,  MINV, 32'hFFFF_FFFF, 0);
    run(1'b0, F3_DIVU, MINV, 32'hFFFF_FFFF, 0);
    run(1'b1, F3_REM,  MINV, 32'hFFFF_FFFF, 0);

    // Flush at CALC cycle 10
    sel = 1'b0; funct3 = F3_DIVU; dividend = 32'd1000; divisor = 32'd7; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", W'(ir1), W'(1));
    chk("flush_out_valid", W'(ov1), W'(0));
    watch_no_valid("flush_calc_no_valid", 40);
    run(1'b0, F3_REM, 32'hFFFF_FF9C, 32'd7, 0);

    // Flush in the same cycle as a request drops it
    funct3 = F3_DIVU; dividend = 32'd50; divisor = 32'd3; iv1 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; flush = 1'b0;
    chk("flush_req_in_ready", W'(ir1), W'(1));
    watch_no_valid("flush_req_no_valid", 40);

    // Flush together with out_ready in DONE
    funct3 = F3_DIVU; dividend = 32'd5; divisor = 32'd0; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    chk("div0_fast_valid", W'(ov1), W'(1));
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_valid", W'(ov1), W'(0));
    chk("flush_done_in_ready", W'(ir1), W'(1));
    chk("flush_done_quotient", q1, W'(0));

    // Async reset: dut1 mid-CALC, dut4 holding a result in DONE
    funct3 = F3_DIV; dividend = 32'd12345; divisor = 32'd11; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    funct3 = F3_REMU; dividend = 32'hABCD; divisor = 32'd0; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    chk("pre_rst_dut4_rem", r4, 32'hABCD);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", W'(ov1), W'(0));
    chk("rst_mid_quotient", q1, W'(0));
    chk("rst_done_out_valid", W'(ov4), W'(0));
    chk("rst_done_quotient", q4, W'(0));
    chk("rst_done_remainder", r4, W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel_in_ready1", W'(ir1), W'(1));
    chk("rst_rel_in_ready4", W'(ir4), W'(1));
    @(negedge clk);
    run(1'b0, F3_DIV, 32'd100, 32'hFFFF_FFFD, 0);

    // Randomized mix including corner operands
    for (int i = 0; i < 40; i++) begin
      s = (i % 4 == 3);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(6))
        0: b = '0;
        1: begin a = MINV; b = '1; end
        2: b = W'($urandom_range(15));
        3: a = W'($urandom_range(1000));
        4: b = b >> $urandom_range(31);
        default: ;
      endcase
      run(s, ops[$urandom_range(3)], a, b, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider_param.md
SEQ_DIVIDER_PARAM -- requirements
Module: seq_divider_param

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; even, 8 to 64.
REQ-002 Parameter STEPS_PER_CYCLE, default 1: restoring iterations per clock; one of 1, 2 or 4, and divides WIDTH.
REQ-003 Port: clk, input, 1, sole clock, rising edge.
REQ-004 Port: rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-005 Port: in_valid, input, 1, request offered.
REQ-006 Port: in_ready, output, 1, block can accept a request.
REQ-007 Port: funct3, input, m_funct3_t, op select; div/rem signed, divu/remu unsigned.
REQ-008 Port: dividend, input, WIDTH, rs1.
REQ-009 Port: divisor, input, WIDTH, rs2.
REQ-010 Port: flush, input, 1, abort any in-flight or pending operation.
REQ-011 Port: out_valid, output, 1, result available.
REQ-012 Port: out_ready, input, 1, consumer accepts result.
REQ-013 Port: quotient, output, WIDTH, registered quotient.
REQ-014 Port: remainder, output, WIDTH, registered remainder.

Function
REQ-015 States IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Accept: in_valid & in_ready & ~flush at edge E; funct3, operands, signs are captured, and later input changes have no effect.
REQ-017 Normal path: IDLE->CALC at E; CALC lasts WIDTH/STEPS_PER_CYCLE cycles; out_valid rises after edge E + WIDTH/STEPS_PER_CYCLE + 1.
REQ-018 Each iteration: shift {rem,quo} left 1; if rem_shifted >= |divisor|, subtract and set quo LSB; unsigned compare on magnitudes, WIDTH+1-bit subtract.
REQ-019 Signed ops: magnitudes used; quotient negated iff dividend and divisor signs differ; remainder negated iff dividend negative; applied on CALC->DONE.
REQ-020 Divisor zero: IDLE->DONE at E, out_valid after E+1; quotient all ones, remainder = dividend.
REQ-021 Signed overflow (div/rem, dividend = MIN, divisor = all ones): IDLE->DONE at E; quotient = MIN, remainder 0.
REQ-022 Unsigned ops with the overflow operands take the normal path.
REQ-023 DONE holds quotient/remainder stable until out_valid & out_ready; then DONE->IDLE, and in_ready is high the following cycle.
REQ-024 quotient and remainder are 0 whenever out_valid is low.
REQ-025 flush in any state: next state IDLE, out_valid low next cycle, in-flight result discarded; flush with in_valid in the same cycle drops the request.
REQ-026 flush and out_ready together in DONE: the result counts as consumed; next state IDLE.
REQ-027 The iteration counter is log2(WIDTH/STEPS_PER_CYCLE)+1 bits and never wraps inside CALC.

Reset
REQ-028 rst asserted, including mid-CALC: state IDLE and all datapath registers 0 immediately; in_ready 1 after release, out_valid 0, quotient 0, remainder 0.
REQ-029 The first accept is the first rising edge with rst low.

Structure
REQ-030 m_funct3_t stays in rv32i_types; the divider state enum and DIV_MAX_STEPS constant go into the same package.
REQ-031 One sub-module, div_step: combinational single restoring iteration, instantiated STEPS_PER_CYCLE times in a chain.
REQ-032 No latches; all state is in one always_ff with asynchronous reset.

Verification
REQ-033 WIDTH 32, STEPS 1, div -7/2 -> q 0xFFFFFFFD, r 0xFFFFFFFF, out_valid 33 cycles after accept.
REQ-034 STEPS 4, divu 0xFFFFFFFF/0x10 -> q 0x0FFFFFFF, r 0xF, out_valid 9 cycles after accept.
REQ-035 rem 0x1234/0 -> q 0xFFFFFFFF, r 0x1234, 1 cycle; div 0x80000000/0xFFFFFFFF -> q 0x80000000, r 0; divu on the same operands -> q 0, r 0x80000000.
REQ-036 out_ready low for 5 cycles in DONE -> outputs stable, in_ready 0; operands changed after accept -> result unchanged.
REQ-037 flush at CALC cycle 10 -> in_ready 1 next cycle, no out_valid; a new request then completes correctly.
REQ-038 rst pulsed mid-CALC between edges -> out_valid, quotient, remainder 0 immediately; in_ready 1 after release.
